// File: rtl/ecc_secded_pipe.sv
// Hamming SECDED encoder (1-cycle) and decoder (2-stage) with error injection
// and saturating error statistics.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH   = 27,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enc_valid,
  input  logic [DATA_WIDTH-1:0]                enc_data,
  input  logic                                 inj_en,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   inj_mask,
  output logic                                 enc_valid_o,
  output logic [DATA_WIDTH-1:0]                enc_data_o,
  output logic [PARITY_WIDTH-1:0]              enc_parity_o,
  input  logic                                 dec_valid,
  input  logic [DATA_WIDTH-1:0]                dec_data,
  input  logic [PARITY_WIDTH-1:0]              dec_parity,
  input  logic                                 bypass,
  output logic                                 dec_valid_o,
  output logic [DATA_WIDTH-1:0]                dec_data_o,
  output logic                                 sbit_err,
  output logic                                 dbit_err,
  output logic [CNT_WIDTH-1:0]                 sbit_cnt,
  output logic [CNT_WIDTH-1:0]                 dbit_cnt,
  output logic [PARITY_WIDTH-1:0]              first_syn,
  output logic                                 err_sticky,
  input  logic                                 cnt_clr
);

  localparam int CW = DATA_WIDTH + PARITY_WIDTH;
  localparam int LW = PARITY_WIDTH - 1;

  // Data bits occupy the non-power-of-two codeword positions from 3 upward.
  function automatic int data_pos(input int k);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int pos = 3; pos < (1 << LW); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == k) res = pos;
        n++;
      end
    end
    return res;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] par_mask(input int i);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < DATA_WIDTH; k++)
      if (((data_pos(k) >> i) & 1) != 0)
        m = m | ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << k);
    return m;
  endfunction

  logic [LW-1:0]         enc_p_lo, dec_p_lo;
  logic [PARITY_WIDTH-1:0] enc_p, dec_syn;

  genvar gi;
  generate
    for (gi = 0; gi < LW; gi++) begin : g_par
      localparam logic [DATA_WIDTH-1:0] MSK = par_mask(gi);
      assign enc_p_lo[gi] = ^(enc_data & MSK);
      assign dec_p_lo[gi] = ^(dec_data & MSK);
    end
  endgenerate

  assign enc_p = {(^enc_data) ^ (^enc_p_lo), enc_p_lo};

  // The overall syndrome bit is the parity of the whole received codeword,
  // so that a single flip anywhere always reads as O=1.
  assign dec_syn = {(^dec_data) ^ (^dec_parity), dec_p_lo ^ dec_parity[LW-1:0]};

  // ---------------- encoder ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid_o  <= 1'b0;
      enc_data_o   <= '0;
      enc_parity_o <= '0;
    end else begin
      enc_valid_o <= enc_valid;
      if (enc_valid)
        {enc_parity_o, enc_data_o} <= {enc_p, enc_data} ^ ({CW{inj_en}} & inj_mask);
    end
  end

  // ---------------- decoder ----------------
  logic [1:0]              dec_vld_pipe;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_syn, s2_syn;
  logic                    s1_byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_vld_pipe <= '0;
      s1_data      <= '0;
      s1_syn       <= '0;
      s1_byp       <= 1'b0;
    end else begin
      dec_vld_pipe <= {dec_vld_pipe[0], dec_valid};
      if (dec_valid) begin
        s1_data <= dec_data;
        s1_syn  <= dec_syn;
        s1_byp  <= bypass;
      end
    end
  end

  assign dec_valid_o = dec_vld_pipe[1];

  logic [DATA_WIDTH-1:0] flip;
  logic [LW-1:0]         s1_lo;
  logic                  s1_ovr;

  assign s1_lo  = s1_syn[LW-1:0];
  assign s1_ovr = s1_syn[LW];

  genvar gk;
  generate
    for (gk = 0; gk < DATA_WIDTH; gk++) begin : g_cor
      localparam logic [LW-1:0] POS = LW'(data_pos(gk));
      assign flip[gk] = (s1_lo == POS);
    end
  endgenerate

  logic [DATA_WIDTH-1:0] cor_data;
  logic                  c_sbit, c_dbit;

  always_comb begin
    cor_data = s1_data;
    c_sbit   = 1'b0;
    c_dbit   = 1'b0;
    if (!s1_byp && (s1_syn != '0)) begin
      if (s1_ovr) begin
        if ((s1_lo & (s1_lo - LW'(1))) == '0) begin
          c_sbit = 1'b1;
        end else if (|flip) begin
          c_sbit   = 1'b1;
          cor_data = s1_data ^ flip;
        end else begin
          c_dbit = 1'b1;
        end
      end else begin
        c_dbit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_data_o <= '0;
      s2_syn     <= '0;
      sbit_err   <= 1'b0;
      dbit_err   <= 1'b0;
    end else begin
      if (dec_vld_pipe[0]) begin
        dec_data_o <= cor_data;
        s2_syn     <= s1_syn;
      end
      sbit_err <= dec_vld_pipe[0] & c_sbit;
      dbit_err <= dec_vld_pipe[0] & c_dbit;
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt   <= '0;
      dbit_cnt   <= '0;
      first_syn  <= '0;
      err_sticky <= 1'b0;
    end else if (cnt_clr) begin
      sbit_cnt   <= '0;
      dbit_cnt   <= '0;
      first_syn  <= '0;
      err_sticky <= 1'b0;
    end else if (dec_valid_o && (sbit_err || dbit_err)) begin
      if (sbit_err && (sbit_cnt != '1)) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (dbit_err && (dbit_cnt != '1)) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      if (!err_sticky) first_syn <= s2_syn;
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed scoreboard bench for ecc_secded_pipe with an independent
// position-based Hamming model.
module tb_ecc_secded_pipe;
  localparam int DW = 27, PW = 7, CNTW = 4, CW = DW + PW, NPOS = 33;

  logic clk, rst;
  logic enc_valid, inj_en, enc_valid_o;
  logic [DW-1:0] enc_data, enc_data_o, dec_data, dec_data_o;
  logic [CW-1:0] inj_mask;
  logic [PW-1:0] enc_parity_o, dec_parity, first_syn;
  logic dec_valid, bypass, dec_valid_o, sbit_err, dbit_err, err_sticky, cnt_clr;
  logic [CNTW-1:0] sbit_cnt, dbit_cnt;

  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data), .inj_en(inj_en), .inj_mask(inj_mask),
    .enc_valid_o(enc_valid_o), .enc_data_o(enc_data_o), .enc_parity_o(enc_parity_o),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_parity(dec_parity), .bypass(bypass),
    .dec_valid_o(dec_valid_o), .dec_data_o(dec_data_o), .sbit_err(sbit_err), .dbit_err(dbit_err),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .first_syn(first_syn), .err_sticky(err_sticky),
    .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sbit;
    logic          dbit;
    logic [PW-1:0] syn;
  } dec_exp_t;

  logic [CW-1:0] enc_q[$];
  dec_exp_t      dec_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Build the codeword by position, then each check bit covers its positions.
  function automatic logic [CW-1:0] model_enc(input logic [DW-1:0] d);
    logic [63:0]   pb;
    logic [PW-1:0] p;
    int k;
    pb = '0;
    k  = 0;
    for (int pos = 1; pos <= NPOS; pos++)
      if (!is_pow2(pos)) begin pb[pos] = d[k]; k++; end
    p = '0;
    for (int i = 0; i < PW - 1; i++)
      for (int pos = 1; pos <= NPOS; pos++)
        if (((pos >> i) & 1) != 0) p[i] = p[i] ^ pb[pos];
    p[PW-1] = (^d) ^ (^p[PW-2:0]);
    return {p, d};
  endfunction

  // Classic decode: syndrome is the XOR of the positions of all set bits.
  function automatic dec_exp_t model_dec(input logic [CW-1:0] cw);
    dec_exp_t r;
    logic [63:0] pb;
    int k, syn, didx;
    logic ovr;
    pb = '0;
    k  = 0;
    for (int pos = 1; pos <= NPOS; pos++)
      if (!is_pow2(pos)) begin pb[pos] = cw[k]; k++; end
    for (int i = 0; i < PW - 1; i++) pb[1 << i] = cw[DW + i];
    syn = 0;
    for (int pos = 1; pos <= NPOS; pos++)
      if (pb[pos]) syn = syn ^ pos;
    ovr    = ^cw;
    r.data = cw[DW-1:0];
    r.sbit = 1'b0;
    r.dbit = 1'b0;
    r.syn  = {ovr, 6'(syn)};
    if (ovr) begin
      if (is_pow2(syn)) r.sbit = 1'b1;
      else if (syn <= NPOS) begin
        didx = 0;
        for (int pos = 3; pos < syn; pos++) if (!is_pow2(pos)) didx++;
        r.sbit = 1'b1;
        r.data[didx] = ~r.data[didx];
      end else r.dbit = 1'b1;
    end else if (syn != 0) r.dbit = 1'b1;
    return r;
  endfunction

  logic [CW-1:0] enc_e;
  dec_exp_t      dec_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (enc_valid_o) begin
        chk("enc_pending", enc_q.size() != 0, 1);
        if (enc_q.size() != 0) begin
          enc_e = enc_q.pop_front();
          chk("enc_cw", {enc_parity_o, enc_data_o}, enc_e);
        end
      end
      if (dec_valid_o) begin
        chk("dec_pending", dec_q.size() != 0, 1);
        chk("flag_excl", sbit_err & dbit_err, 0);
        if (dec_q.size() != 0) begin
          dec_e = dec_q.pop_front();
          chk("dec_data", dec_data_o, dec_e.data);
          chk("sbit_err", sbit_err, dec_e.sbit);
          chk("dbit_err", dbit_err, dec_e.dbit);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enc(input logic [DW-1:0] d, input logic [CW-1:0] mask);
    enc_valid = 1'b1;
    enc_data  = d;
    inj_en    = (mask != '0);
    inj_mask  = mask;
    enc_q.push_back(model_enc(d) ^ mask);
    step();
    enc_valid = 1'b0;
    inj_en    = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic dec_drive(input logic [CW-1:0] stim, input logic [CW-1:0] mdl, input logic byp);
    dec_exp_t x;
    dec_valid  = 1'b1;
    dec_data   = stim[DW-1:0];
    dec_parity = stim[CW-1:DW];
    bypass     = byp;
    x = model_dec(mdl);
    if (byp) begin
      x.data = mdl[DW-1:0];
      x.sbit = 1'b0;
      x.dbit = 1'b0;
    end
    dec_q.push_back(x);
    step();
    dec_valid = 1'b0;
    bypass    = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (dec_q.size() + enc_q.size()) != 0; i++) step();
    step();
    chk(tag, dec_q.size() + enc_q.size(), 0);
  endtask

  task automatic enc_dec(input logic [DW-1:0] d, input logic [CW-1:0] mask);
    enc(d, mask);
    dec_drive({enc_parity_o, enc_data_o}, model_enc(d) ^ mask, 1'b0);
    drain("drain_encdec");
  endtask

  logic [DW-1:0] rd;
  logic [CW-1:0] cw;
  logic [PW-1:0] exp_first;

  initial begin
    rst = 1'b1; enc_valid = 1'b0; enc_data = '0; inj_en = 1'b0; inj_mask = '0;
    dec_valid = 1'b0; dec_data = '0; dec_parity = '0; bypass = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enc_valid", enc_valid_o, 0);
    chk("rst_enc_data", {enc_parity_o, enc_data_o}, 0);
    chk("rst_dec_valid", dec_valid_o, 0);
    chk("rst_dec_data", dec_data_o, 0);
    chk("rst_stats", {sbit_cnt, dbit_cnt, first_syn, err_sticky}, 0);

    // clean round trip; the encode lands on the first edge after release
    rst = 1'b0;
    enc_dec(27'h0000001, '0);
    chk("clean_cnt", {sbit_cnt, dbit_cnt, err_sticky}, 0);

    // single data-bit error
    enc_dec(27'h5A5A5A5, 34'h1);
    exp_first = model_dec(model_enc(27'h5A5A5A5) ^ 34'h1).syn;
    chk("single_sbit_cnt", sbit_cnt, 1);
    chk("single_dbit_cnt", dbit_cnt, 0);
    chk("single_sticky", err_sticky, 1);
    chk("single_first_syn", first_syn, exp_first);

    // double error: first_syn stays
    enc_dec(27'h5A5A5A5, 34'h21);
    chk("double_dbit_cnt", dbit_cnt, 1);
    chk("double_sbit_cnt", sbit_cnt, 1);
    chk("double_first_syn", first_syn, exp_first);

    // parity-bit errors and a syndrome beyond the last position, back to back
    cw = model_enc(27'h7FFFFFF);
    dec_drive(cw ^ (34'h1 << 27), cw ^ (34'h1 << 27), 1'b0);
    dec_drive(cw ^ (34'h1 << 33), cw ^ (34'h1 << 33), 1'b0);
    cw = model_enc(27'h1234567) ^ ((34'h1 << 32) | 34'h14);
    dec_drive(cw, cw, 1'b0);
    cw = model_enc(27'h0);
    dec_drive(cw, cw, 1'b0);
    drain("drain_edges");
    chk("edges_sbit_cnt", sbit_cnt, 3);
    chk("edges_dbit_cnt", dbit_cnt, 2);

    // saturate sbit_cnt with back-to-back single errors anywhere in the codeword
    for (int n = 0; n < 20; n++) begin
      rd = DW'($urandom);
      cw = model_enc(rd) ^ (34'h1 << $urandom_range(0, CW - 1));
      dec_drive(cw, cw, 1'b0);
    end
    drain("drain_sat");
    chk("sat_sbit_cnt", sbit_cnt, 4'hF);

    // clear coinciding with an error update wins
    cw = model_enc(27'h0ABCDEF) ^ 34'h3;
    dec_drive(cw, cw, 1'b0);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sbit_cnt", sbit_cnt, 0);
    chk("clr_dbit_cnt", dbit_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_first_syn", first_syn, 0);

    // first_syn reloads after clear
    cw = model_enc(27'h3000000) ^ (34'h1 << 26);
    dec_drive(cw, cw, 1'b0);
    drain("drain_reload");
    chk("reload_first_syn", first_syn, model_dec(cw).syn);
    chk("reload_sbit_cnt", sbit_cnt, 1);

    // bypass passes corrupted data, no flags, no counting
    cw = model_enc(27'h1555555) ^ (34'h1 << 9);
    dec_drive(cw, cw, 1'b1);
    drain("drain_bypass");
    chk("byp_sbit_cnt", sbit_cnt, 1);
    chk("byp_dbit_cnt", dbit_cnt, 0);

    // reset with two decodes in flight
    cw = model_enc(27'h0F0F0F0) ^ 34'h2;
    dec_drive(cw, cw, 1'b0);
    cw = model_enc(27'h0F0F0F0) ^ 34'h6;
    dec_drive(cw, cw, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_dec_valid", dec_valid_o, 0);
    chk("async_dec_out", {dec_data_o, sbit_err, dbit_err}, 0);
    chk("async_stats", {sbit_cnt, dbit_cnt, first_syn, err_sticky}, 0);
    dec_q.delete();
    step();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("post_rst_no_valid", dec_valid_o, 0);
    end
    cw = model_enc(27'h7654321);
    dec_drive(cw, cw, 1'b0);
    chk("lat_cycle1", dec_valid_o, 0);
    step();
    chk("lat_cycle2", dec_valid_o, 1);
    drain("drain_post_rst");

    // encoder holds when idle
    enc(27'h2468ACE, '0);
    step();
    chk("enc_hold_valid", enc_valid_o, 0);
    chk("enc_hold_data", {enc_parity_o, enc_data_o}, model_enc(27'h2468ACE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
